// File: rtl/aes_dec_sequencer.sv
// Control/buffer stage ahead of the iterative AES-128 decrypt datapath.
// Define AES_DEC_KEY_LATCH_EN to register key_in at the input handshake.
module aes_dec_sequencer #(
    parameter logic [5:0] CNT_FIRST = 6'd10,
    parameter logic [5:0] CNT_LAST  = 6'd20,
    parameter logic [5:0] CNT_PARK  = 6'd21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    input  logic [127:0] key_in,
    output logic [127:0] dp_block,
    output logic [127:0] dp_key,
    output logic [5:0]   dp_counter,
    input  logic [127:0] dp_out,
    output logic [127:0] pt_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [5:0]   r_cnt;
    logic [5:0]   w_cnt_next;
    logic [127:0] r_ct;
    logic [127:0] r_pt;
    logic         r_out_valid;
    logic         w_accept;

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  w_next = S_ROUND;
            S_ROUND: if (r_cnt == CNT_LAST - 6'd1) w_next = S_FINAL;
            S_FINAL: w_next = S_DONE;
            S_DONE: begin
                if (out_ready) w_next = w_accept ? S_LOAD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_LOAD:  busy = 1'b1;
            S_ROUND: busy = 1'b1;
            S_FINAL: busy = 1'b1;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Counter is registered and derived from the next state so it lines
    // up with the state it belongs to.
    always_comb begin
        w_cnt_next = CNT_PARK;
        unique case (w_next)
            S_LOAD:  w_cnt_next = CNT_FIRST;
            S_ROUND: w_cnt_next = r_cnt + 6'd1;
            S_FINAL: w_cnt_next = CNT_LAST;
            default: w_cnt_next = CNT_PARK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= CNT_PARK;
            r_ct        <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_accept) r_ct <= ct_in;
            if (r_state == S_FINAL) begin
                r_pt        <= dp_out;
                r_out_valid <= 1'b1;
            end else if (r_state == S_DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef AES_DEC_KEY_LATCH_EN
    logic [127:0] r_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key <= '0;
        end else if (w_accept) begin
            r_key <= key_in;
        end
    end

    assign dp_key = r_key;
`else
    assign dp_key = key_in;
`endif

    assign dp_block   = r_ct;
    assign dp_counter = r_cnt;
    assign pt_out     = r_pt;
    assign out_valid  = r_out_valid;

endmodule
